// File: rtl/prb_cfg_loader.sv
// prb_cfg_loader: serialises acceptance-filter parameter sets into the
// parameter registry's byte-strobe protocol.
//
// A host hands over a complete set (11-bit mask, 11-bit code, 2-bit SJW) on a
// valid/ready handshake. One set can wait in a shadow register while another
// is being sent from the active register. Each set is sent as three
// single-cycle param_id strobes carrying one byte each. GAP_CYCLES idle cycles
// follow every strobe. A one-cycle done pulse then ends the load.
//
// Parameters:
//   GAP_CYCLES  idle cycles after each strobe (1..255)
//   CNT_W       width of load_count
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   cfg_valid   host offers a parameter set
//   cfg_ready   loader can accept a set (0 while reset is low)
//   cfg_mask    11-bit mask value
//   cfg_code    11-bit code value
//   cfg_sjw     2-bit SJW value
//   param_id    one-cycle strobe to the registry
//   data        registry byte, 8'h00 whenever param_id is low
//   busy        a load is in progress
//   done        one-cycle pulse at the end of each load
//   load_count  completed loads, wraps modulo 2^CNT_W
module prb_cfg_loader #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [10:0]      cfg_mask,
  input  logic [10:0]      cfg_code,
  input  logic [1:0]       cfg_sjw,
  output logic             param_id,
  output logic [7:0]       data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] load_count
);

  localparam int unsigned MASK_W = 11;
  localparam int unsigned CODE_W = 11;
  localparam int unsigned SJW_W  = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned GAP_W  = 8;
  localparam int unsigned IDX_W  = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [GAP_W-1:0]    gap_cnt;

  logic [MASK_W-1:0]   shadow_mask;
  logic [CODE_W-1:0]   shadow_code;
  logic [SJW_W-1:0]    shadow_sjw;
  logic                shadow_full;

  logic [MASK_W-1:0]   act_mask;
  logic [CODE_W-1:0]   act_code;
  logic [SJW_W-1:0]    act_sjw;

  logic                accept;
  logic                take_shadow;

  // Selects one of the three registry bytes of a parameter set.
  function automatic logic [BYTE_W-1:0] pack_byte(
    input logic [MASK_W-1:0] mask,
    input logic [CODE_W-1:0] code,
    input logic [SJW_W-1:0]  sjw,
    input logic [IDX_W-1:0]  sel
  );
    logic [BYTE_W-1:0] b;
    b = '0;
    case (sel)
      2'd0:    b = mask[10:3];
      2'd1:    b = {mask[2:0], code[10:6]};
      default: b = {code[5:0], sjw};
    endcase
    return b;
  endfunction

  // Ready follows the shadow occupancy; reset forces it low combinationally
  // so no handshake can complete while the block is being cleared.
  assign cfg_ready = reset && !shadow_full;
  assign accept    = cfg_valid && cfg_ready;

  // A queued set starts as soon as the loader is between loads. Because
  // cfg_ready is low whenever the shadow is full, an accept can never
  // coincide with this transfer (that cycle is the one-cycle bubble).
  assign take_shadow = shadow_full && ((state == IDLE) || (state == FIN));

  // Loader FSM with registered strobe/data/busy/done outputs. Outputs are
  // set on the edge that enters a state so they line up with that state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      gap_cnt     <= '0;
      shadow_mask <= '0;
      shadow_code <= '0;
      shadow_sjw  <= '0;
      shadow_full <= 1'b0;
      act_mask    <= '0;
      act_code    <= '0;
      act_sjw     <= '0;
      param_id    <= 1'b0;
      data        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_count  <= '0;
    end else begin
      // Strobe and done are single-cycle; data is zero outside a strobe.
      param_id <= 1'b0;
      data     <= '0;
      done     <= 1'b0;

      // Host values are captured only here, at the handshake.
      if (accept) begin
        shadow_mask <= cfg_mask;
        shadow_code <= cfg_code;
        shadow_sjw  <= cfg_sjw;
        shadow_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          busy <= 1'b0;
        end

        SEND: begin
          gap_cnt <= GAP_LOAD;
          state   <= GAP;
        end

        GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            if (idx < LAST_IDX) begin
              idx      <= idx + IDX_W'(1);
              state    <= SEND;
              param_id <= 1'b1;
              data     <= pack_byte(act_mask, act_code, act_sjw,
                                    idx + IDX_W'(1));
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        FIN: begin
          load_count <= load_count + CNT_W'(1);
          state      <= IDLE;
          busy       <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Shadow-to-active transfer from IDLE or FIN; issues byte0 directly
      // so the first strobe lands in the cycle after the transfer.
      if (take_shadow) begin
        act_mask    <= shadow_mask;
        act_code    <= shadow_code;
        act_sjw     <= shadow_sjw;
        shadow_full <= 1'b0;
        idx         <= '0;
        state       <= SEND;
        busy        <= 1'b1;
        param_id    <= 1'b1;
        data        <= pack_byte(shadow_mask, shadow_code, shadow_sjw,
                                 IDX_W'(0));
      end
    end
  end

endmodule
